// File: rtl/scu_dsp_dma_bridge.sv
// SCU DSP DMA bridge: turns DSP word requests into one A-bus cycle
// or two B-bus halfword cycles, with a per-phase timeout.
module scu_dsp_dma_bridge #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CE_R,
    input  logic [26:0] DMA_A,
    input  logic [31:0] DMA_DO,
    input  logic        DMA_WE,
    input  logic        DMA_REQ,
    output logic        DMA_ACK,
    output logic [31:0] DMA_DI,
    output logic [26:0] ABUS_A,
    output logic [31:0] ABUS_DO,
    output logic        ABUS_WE,
    output logic        ABUS_REQ,
    input  logic [31:0] ABUS_DI,
    input  logic        ABUS_ACK,
    output logic [26:0] BBUS_A,
    output logic [15:0] BBUS_DO,
    output logic        BBUS_WE,
    output logic        BBUS_REQ,
    input  logic [15:0] BBUS_DI,
    input  logic        BBUS_ACK,
    output logic        BUS_ERR,
    output logic        BUSY
);

    localparam int CW = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;

    typedef enum logic [2:0] {IDLE, ACYC, BHI, BLO, RESP} state_t;

    state_t          state;
    logic            we_q;
    logic [15:0]     do_lo;
    logic [15:0]     rd_hi;
    logic [CW-1:0]   cnt;
    logic [26:0]     a_al;
    logic            is_b;
    logic            tmo;

    assign a_al = DMA_A & ~27'd3;
    assign is_b = (DMA_A[26:24] == 3'b101) && (DMA_A[23:20] >= 4'hA);
    assign tmo  = (TIMEOUT_CYC != 0) && (cnt == CW'(TIMEOUT_CYC - 1));
    assign BUSY = (state != IDLE);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            do_lo    <= '0;
            rd_hi    <= '0;
            cnt      <= '0;
            DMA_ACK  <= 1'b0;
            DMA_DI   <= '0;
            ABUS_A   <= '0;
            ABUS_DO  <= '0;
            ABUS_WE  <= 1'b0;
            ABUS_REQ <= 1'b0;
            BBUS_A   <= '0;
            BBUS_DO  <= '0;
            BBUS_WE  <= 1'b0;
            BBUS_REQ <= 1'b0;
            BUS_ERR  <= 1'b0;
        end else if (CE_R) begin
            DMA_ACK <= 1'b0;
            BUS_ERR <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (DMA_REQ) begin
                        we_q  <= DMA_WE;
                        do_lo <= DMA_DO[15:0];
                        cnt   <= '0;
                        if (is_b) begin
                            state    <= BHI;
                            BBUS_REQ <= 1'b1;
                            BBUS_A   <= a_al;
                            BBUS_DO  <= DMA_DO[31:16];
                            BBUS_WE  <= DMA_WE;
                        end else begin
                            state    <= ACYC;
                            ABUS_REQ <= 1'b1;
                            ABUS_A   <= a_al;
                            ABUS_DO  <= DMA_DO;
                            ABUS_WE  <= DMA_WE;
                        end
                    end
                end
                ACYC: begin
                    if (ABUS_ACK || tmo) begin
                        ABUS_REQ <= 1'b0;
                        BUS_ERR  <= !ABUS_ACK;
                        DMA_ACK  <= 1'b1;
                        DMA_DI   <= (we_q || !ABUS_ACK) ? 32'h0 : ABUS_DI;
                        state    <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BHI: begin
                    if (BBUS_ACK || tmo) begin
                        BBUS_REQ <= 1'b0;
                        BUS_ERR  <= !BBUS_ACK;
                        rd_hi    <= BBUS_ACK ? BBUS_DI : 16'h0;
                        BBUS_A   <= BBUS_A + 27'd2;
                        BBUS_DO  <= do_lo;
                        state    <= BLO;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BLO: begin
                    // first BLO tick is the mandatory REQ gap; ACK is ignored
                    if (!BBUS_REQ) begin
                        BBUS_REQ <= 1'b1;
                        cnt      <= '0;
                    end else if (BBUS_ACK || tmo) begin
                        BBUS_REQ <= 1'b0;
                        BUS_ERR  <= !BBUS_ACK;
                        DMA_ACK  <= 1'b1;
                        DMA_DI   <= we_q ? 32'h0 :
                                    {rd_hi, BBUS_ACK ? BBUS_DI : 16'h0};
                        state    <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scu_dsp_dma_bridge.sv
// Directed bench for scu_dsp_dma_bridge: A/B-bus transfers, timeout,
// streaming, clock-enable hold and mid-transfer reset.
module tb_scu_dsp_dma_bridge;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        CE_R;
    logic [26:0] DMA_A;
    logic [31:0] DMA_DO;
    logic        DMA_WE;
    logic        DMA_REQ;
    logic        DMA_ACK;
    logic [31:0] DMA_DI;
    logic [26:0] ABUS_A;
    logic [31:0] ABUS_DO;
    logic        ABUS_WE;
    logic        ABUS_REQ;
    logic [31:0] ABUS_DI;
    logic        ABUS_ACK;
    logic [26:0] BBUS_A;
    logic [15:0] BBUS_DO;
    logic        BBUS_WE;
    logic        BBUS_REQ;
    logic [15:0] BBUS_DI;
    logic        BBUS_ACK;
    logic        BUS_ERR;
    logic        BUSY;

    int vectors = 0;
    int miscompares = 0;
    int acks = 0;

    scu_dsp_dma_bridge #(.TIMEOUT_CYC(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R),
        .DMA_A(DMA_A), .DMA_DO(DMA_DO), .DMA_WE(DMA_WE),
        .DMA_REQ(DMA_REQ), .DMA_ACK(DMA_ACK), .DMA_DI(DMA_DI),
        .ABUS_A(ABUS_A), .ABUS_DO(ABUS_DO), .ABUS_WE(ABUS_WE),
        .ABUS_REQ(ABUS_REQ), .ABUS_DI(ABUS_DI), .ABUS_ACK(ABUS_ACK),
        .BBUS_A(BBUS_A), .BBUS_DO(BBUS_DO), .BBUS_WE(BBUS_WE),
        .BBUS_REQ(BBUS_REQ), .BBUS_DI(BBUS_DI), .BBUS_ACK(BBUS_ACK),
        .BUS_ERR(BUS_ERR), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [26:0] a, input logic we,
                       input logic [31:0] d);
        DMA_A   = a;
        DMA_WE  = we;
        DMA_DO  = d;
        DMA_REQ = 1'b1;
        tick();
        DMA_REQ = 1'b0;
    endtask

    initial begin
        RST_N = 1'b0; CE_R = 1'b1;
        DMA_A = '0; DMA_DO = '0; DMA_WE = 1'b0; DMA_REQ = 1'b0;
        ABUS_DI = '0; ABUS_ACK = 1'b0; BBUS_DI = '0; BBUS_ACK = 1'b0;
        tick(); tick();
        chk("rst_dma_ack", {31'd0, DMA_ACK}, 32'd0);
        chk("rst_dma_di", DMA_DI, 32'd0);
        chk("rst_abus_req", {31'd0, ABUS_REQ}, 32'd0);
        chk("rst_bbus_req", {31'd0, BBUS_REQ}, 32'd0);
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_bus_err", {31'd0, BUS_ERR}, 32'd0);
        RST_N = 1'b1;
        tick();

        // A-bus read, ACK sampled on the third REQ tick
        req(27'h6000100, 1'b0, 32'h0);
        chk("t1_abus_req", {31'd0, ABUS_REQ}, 32'd1);
        chk("t1_abus_a", {5'd0, ABUS_A}, 32'h6000100);
        chk("t1_bbus_req", {31'd0, BBUS_REQ}, 32'd0);
        chk("t1_busy", {31'd0, BUSY}, 32'd1);
        tick(); tick();
        chk("t1_wait_ack", {31'd0, DMA_ACK}, 32'd0);
        ABUS_ACK = 1'b1; ABUS_DI = 32'hDEADBEEF;
        tick();
        ABUS_ACK = 1'b0; ABUS_DI = 32'h0;
        chk("t1_req_drop", {31'd0, ABUS_REQ}, 32'd0);
        chk("t1_dma_ack", {31'd0, DMA_ACK}, 32'd1);
        chk("t1_dma_di", DMA_DI, 32'hDEADBEEF);
        chk("t1_bus_err", {31'd0, BUS_ERR}, 32'd0);
        tick();
        chk("t1_ack_pulse", {31'd0, DMA_ACK}, 32'd0);
        chk("t1_idle", {31'd0, BUSY}, 32'd0);
        chk("t1_di_hold", DMA_DI, 32'hDEADBEEF);

        // B-bus write, zero wait; ACK held high through the gap tick
        req(27'h5C00010, 1'b1, 32'h12345678);
        chk("t2_bbus_req", {31'd0, BBUS_REQ}, 32'd1);
        chk("t2_bbus_a_hi", {5'd0, BBUS_A}, 32'h5C00010);
        chk("t2_bbus_do_hi", {16'd0, BBUS_DO}, 32'h1234);
        chk("t2_bbus_we", {31'd0, BBUS_WE}, 32'd1);
        chk("t2_abus_req", {31'd0, ABUS_REQ}, 32'd0);
        BBUS_ACK = 1'b1;
        tick();
        chk("t2_gap", {31'd0, BBUS_REQ}, 32'd0);
        chk("t2_bbus_a_lo", {5'd0, BBUS_A}, 32'h5C00012);
        chk("t2_bbus_do_lo", {16'd0, BBUS_DO}, 32'h5678);
        tick();
        chk("t2_lo_req", {31'd0, BBUS_REQ}, 32'd1);
        chk("t2_no_early_ack", {31'd0, DMA_ACK}, 32'd0);
        tick();
        BBUS_ACK = 1'b0;
        chk("t2_dma_ack", {31'd0, DMA_ACK}, 32'd1);
        chk("t2_dma_di_wr", DMA_DI, 32'h0);
        chk("t2_req_drop", {31'd0, BBUS_REQ}, 32'd0);
        tick();
        chk("t2_ack_pulse", {31'd0, DMA_ACK}, 32'd0);

        // B-bus read; junk on the bus during the gap must be ignored
        req(27'h5A00020, 1'b0, 32'h0);
        BBUS_ACK = 1'b1; BBUS_DI = 16'hAAAA;
        tick();
        BBUS_DI = 16'hFFFF;
        tick();
        chk("t3_abus_idle", {31'd0, ABUS_REQ}, 32'd0);
        chk("t3_di_hold", DMA_DI, 32'h0);
        BBUS_DI = 16'h5555;
        tick();
        BBUS_ACK = 1'b0; BBUS_DI = 16'h0;
        chk("t3_dma_ack", {31'd0, DMA_ACK}, 32'd1);
        chk("t3_dma_di", DMA_DI, 32'hAAAA5555);
        chk("t3_abus_idle2", {31'd0, ABUS_REQ}, 32'd0);
        tick();

        // region boundary 0x59FFFFC stays on the A-bus; CE_R=0 freezes
        req(27'h59FFFFC, 1'b0, 32'h0);
        chk("t3b_abus_req", {31'd0, ABUS_REQ}, 32'd1);
        chk("t3b_bbus_req", {31'd0, BBUS_REQ}, 32'd0);
        ABUS_ACK = 1'b1; ABUS_DI = 32'hCAFEF00D; CE_R = 1'b0;
        tick();
        chk("t3b_ce_hold_req", {31'd0, ABUS_REQ}, 32'd1);
        chk("t3b_ce_hold_ack", {31'd0, DMA_ACK}, 32'd0);
        CE_R = 1'b1;
        tick();
        ABUS_ACK = 1'b0;
        chk("t3b_dma_di", DMA_DI, 32'hCAFEF00D);
        tick();

        // timeout after 4 REQ ticks without ACK
        req(27'h6000200, 1'b0, 32'h0);
        tick(); tick(); tick();
        chk("t4_req_held", {31'd0, ABUS_REQ}, 32'd1);
        chk("t4_no_err_yet", {31'd0, BUS_ERR}, 32'd0);
        tick();
        chk("t4_req_drop", {31'd0, ABUS_REQ}, 32'd0);
        chk("t4_bus_err", {31'd0, BUS_ERR}, 32'd1);
        chk("t4_dma_ack", {31'd0, DMA_ACK}, 32'd1);
        chk("t4_dma_di", DMA_DI, 32'h0);
        tick();
        chk("t4_err_pulse", {31'd0, BUS_ERR}, 32'd0);
        chk("t4_idle", {31'd0, BUSY}, 32'd0);

        // streaming DSP: next REQ the tick after each ACK; low bits forced 00
        for (int i = 0; i < 3; i++) begin
            req(27'h6000000 + 27'(4 * i + i), 1'b0, 32'h0);
            chk("t5_abus_a", {5'd0, ABUS_A}, 32'h6000000 + 32'(4 * i));
            ABUS_ACK = 1'b1; ABUS_DI = 32'h1000 + 32'(i);
            tick();
            ABUS_ACK = 1'b0;
            if (DMA_ACK === 1'b1) acks++;
            chk("t5_dma_di", DMA_DI, 32'h1000 + 32'(i));
            tick();
        end
        chk("t5_ack_count", 32'(acks), 32'd3);

        // reset while in BLO drops the word
        req(27'h5B00000, 1'b0, 32'h0);
        BBUS_ACK = 1'b1; BBUS_DI = 16'h1111;
        tick();
        BBUS_ACK = 1'b0;
        chk("t6_in_blo", {5'd0, BBUS_A}, 32'h5B00002);
        RST_N = 1'b0;
        #1;
        chk("t6_bbus_a", {5'd0, BBUS_A}, 32'h0);
        chk("t6_bbus_req", {31'd0, BBUS_REQ}, 32'd0);
        chk("t6_busy", {31'd0, BUSY}, 32'd0);
        chk("t6_dma_di", DMA_DI, 32'h0);
        tick();
        RST_N = 1'b1;
        tick();
        chk("t6_no_ack", {31'd0, DMA_ACK}, 32'd0);
        req(27'h6000300, 1'b0, 32'h0);
        ABUS_ACK = 1'b1; ABUS_DI = 32'h13579BDF;
        tick();
        ABUS_ACK = 1'b0;
        chk("t6_new_ack", {31'd0, DMA_ACK}, 32'd1);
        chk("t6_new_di", DMA_DI, 32'h13579BDF);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
